// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
// Contents: arbiter state encoding, arbitration mode selectors and the
// funct3-style access size encodings carried through to the memory.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StWait  = 2'd2,
        StResp  = 2'd3
    } arb_state_e;

    localparam int unsigned MODE_FIXED = 0;
    localparam int unsigned MODE_RR    = 1;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection for the memory port arbiter.
// Ports:
//   req_i   - per-channel request vector
//   ptr_i   - round-robin search start (ignored in fixed-priority mode)
//   gnt_o   - one-hot winner
//   idx_o   - winner index
//   valid_o - at least one request present
module arb_pick
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned MODE   = MODE_FIXED
) (
    input  logic [NUM_CH-1:0]         req_i,
    input  logic [$clog2(NUM_CH)-1:0] ptr_i,
    output logic [NUM_CH-1:0]         gnt_o,
    output logic [$clog2(NUM_CH)-1:0] idx_o,
    output logic                      valid_o
);

    localparam int unsigned IW   = $clog2(NUM_CH);
    localparam logic        RrEn = (MODE == MODE_RR);

    logic [IW-1:0] cand;
    logic          found;

    // Search NUM_CH candidates starting at the pointer; with RrEn low the
    // start is forced to 0, which is plain lowest-index priority.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = IW'((32'(ptr_i & {IW{RrEn}}) + k) % NUM_CH);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between NUM_CH requesters using a registered
// request/grant/response handshake (IDLE -> ISSUE -> WAIT -> RESP).
// Ports:
//   clk_i, rst_i         - clock, synchronous active-high reset
//   ch_req_i/ch_we_i     - per-channel request and store flag
//   ch_addr_i/wdata_i    - flattened per-channel address / store data
//   ch_size_i            - flattened per-channel access size
//   ch_kill_i            - drop the pending response of that channel
//   ch_gnt_o             - one-cycle one-hot grant
//   ch_rvalid_o          - one-cycle one-hot response strobe
//   ch_rdata_o           - shared response data
//   busy_o               - access in flight
//   mem_*                - memory command (registered) and read data return
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_CH  = 2,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32,
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned MODE    = MODE_FIXED
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_CH-1:0]    ch_req_i,
    input  logic [NUM_CH-1:0]    ch_we_i,
    input  logic [NUM_CH*AW-1:0] ch_addr_i,
    input  logic [NUM_CH*DW-1:0] ch_wdata_i,
    input  logic [NUM_CH*3-1:0]  ch_size_i,
    input  logic [NUM_CH-1:0]    ch_kill_i,
    output logic [NUM_CH-1:0]    ch_gnt_o,
    output logic [NUM_CH-1:0]    ch_rvalid_o,
    output logic [DW-1:0]        ch_rdata_o,
    output logic                 busy_o,
    output logic                 mem_en_o,
    output logic                 mem_we_o,
    output logic [AW-1:0]        mem_addr_o,
    output logic [DW-1:0]        mem_wdata_o,
    output logic [2:0]           mem_size_o,
    input  logic [DW-1:0]        mem_rdata_i
);

    localparam int unsigned IW      = $clog2(NUM_CH);
    localparam int unsigned CW      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] LatLoad = CW'(MEM_LAT - 1);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_q, rr_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [2:0]    size_q, size_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          kill_q, kill_d;
    logic [DW-1:0] cap_q, cap_d;
    logic [DW-1:0] hold_q, hold_d;

    logic [NUM_CH-1:0] pick_gnt;
    logic [IW-1:0]     pick_idx;
    logic              pick_valid;
    logic              grant_ok;
    logic              owner_kill;
    logic              resp_killed;
    logic              sel_we;
    logic [AW-1:0]     sel_addr;
    logic [DW-1:0]     sel_wdata;
    logic [2:0]        sel_size;

    arb_pick #(
        .NUM_CH (NUM_CH),
        .MODE   (MODE)
    ) u_arb_pick (
        .req_i   (ch_req_i),
        .ptr_i   (rr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign grant_ok    = ((state_q == StIdle) || (state_q == StResp)) && pick_valid;
    assign owner_kill  = ch_kill_i[owner_q];
    // A kill seen during RESP itself still suppresses the response.
    assign resp_killed = kill_q | owner_kill;

    // Winner's command fields, sampled only when a grant is given.
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        sel_size  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (pick_idx == IW'(i)) begin
                sel_we    = ch_we_i[i];
                sel_addr  = ch_addr_i[i*AW +: AW];
                sel_wdata = ch_wdata_i[i*DW +: DW];
                sel_size  = ch_size_i[i*3 +: 3];
            end
        end
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (grant_ok) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  if (cnt_q == '0) state_d = StResp;
            StResp:  state_d = grant_ok ? StIssue : StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state.
    always_comb begin
        owner_d = owner_q;
        rr_d    = rr_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        cnt_d   = cnt_q;
        kill_d  = kill_q;
        cap_d   = cap_q;
        hold_d  = hold_q;

        if (grant_ok) begin
            owner_d = pick_idx;
            we_d    = sel_we;
            addr_d  = sel_addr;
            wdata_d = sel_wdata;
            size_d  = sel_size;
            kill_d  = 1'b0;
            rr_d    = (pick_idx == IW'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
        end

        if (state_q == StIssue) begin
            cnt_d = LatLoad;
        end else if ((state_q == StWait) && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end

        if (((state_q == StIssue) || (state_q == StWait)) && owner_kill) begin
            kill_d = 1'b1;
        end

        // Last WAIT cycle: memory data is valid now (writes captured too).
        if ((state_q == StWait) && (cnt_q == '0)) begin
            cap_d = mem_rdata_i;
        end

        // Remember delivered data so a killed response leaves ch_rdata as it was.
        if ((state_q == StResp) && !resp_killed) begin
            hold_d = cap_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            owner_q <= '0;
            rr_q    <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            kill_q  <= 1'b0;
            cap_q   <= '0;
            hold_q  <= '0;
        end else begin
            owner_q <= owner_d;
            rr_q    <= rr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            kill_q  <= kill_d;
            cap_q   <= cap_d;
            hold_q  <= hold_d;
        end
    end

    // Outputs.
    always_comb begin
        ch_gnt_o    = grant_ok ? pick_gnt : '0;
        ch_rvalid_o = '0;
        ch_rdata_o  = hold_q;
        busy_o      = (state_q != StIdle);
        mem_en_o    = (state_q == StIssue);
        mem_we_o    = (state_q == StIssue) && we_q;
        mem_addr_o  = addr_q;
        mem_wdata_o = wdata_q;
        mem_size_o  = size_q;
        if ((state_q == StResp) && !resp_killed) begin
            ch_rvalid_o[owner_q] = 1'b1;
            ch_rdata_o           = cap_q;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int NI = 4;  // 0: LAT1/fixed  1: LAT1/rr  2: LAT3/fixed  3: LAT4/fixed

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  ch_req = '0;
    logic [1:0]  ch_we = '0;
    logic [1:0]  ch_kill = '0;
    logic [63:0] ch_addr = '0;
    logic [63:0] ch_wdata = '0;
    logic [5:0]  ch_size = '0;

    logic [1:0]  gnt_w    [NI];
    logic [1:0]  rvalid_w [NI];
    logic [31:0] rdata_w  [NI];
    logic [31:0] maddr_w  [NI];
    logic [31:0] mwdata_w [NI];
    logic [2:0]  msize_w  [NI];
    logic        busy_w   [NI];
    logic        en_w     [NI];
    logic        we_w     [NI];

    typedef struct {
        int          inst;
        int          ch;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t     sb_q[$];
    int       errors = 0;
    int       checks = 0;
    int       cyc = 0;
    logic [3:0] track = '0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned Lat  = (g == 2) ? 3 : (g == 3) ? 4 : 1;
        localparam int unsigned Mode = (g == 1) ? MODE_RR : MODE_FIXED;
        int unsigned pend = 0;
        logic [31:0] pdata = '0;
        logic [31:0] mrdata;

        // Memory: data valid exactly Lat cycles after the mem_en cycle.
        always @(posedge clk) begin
            if (en_w[g]) begin
                pend  <= Lat;
                pdata <= mem_fn(maddr_w[g]);
            end else if (pend != 0) begin
                pend <= pend - 1;
            end
        end
        assign mrdata = (pend == 1) ? pdata : 32'hBAD0_BAD0;

        mem_port_arbiter #(
            .NUM_CH  (2),
            .AW      (32),
            .DW      (32),
            .MEM_LAT (Lat),
            .MODE    (Mode)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst),
            .ch_req_i    (ch_req),
            .ch_we_i     (ch_we),
            .ch_addr_i   (ch_addr),
            .ch_wdata_i  (ch_wdata),
            .ch_size_i   (ch_size),
            .ch_kill_i   (ch_kill),
            .ch_gnt_o    (gnt_w[g]),
            .ch_rvalid_o (rvalid_w[g]),
            .ch_rdata_o  (rdata_w[g]),
            .busy_o      (busy_w[g]),
            .mem_en_o    (en_w[g]),
            .mem_we_o    (we_w[g]),
            .mem_addr_o  (maddr_w[g]),
            .mem_wdata_o (mwdata_w[g]),
            .mem_size_o  (msize_w[g]),
            .mem_rdata_i (mrdata)
        );
    end

    // Response scoreboard for tracked instances.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            if (track[i] && rvalid_w[i] != 2'b00) begin
                int idx;
                idx = -1;
                for (int k = 0; k < sb_q.size(); k++) begin
                    if (idx < 0 && sb_q[k].inst == i) idx = k;
                end
                if (idx < 0) begin
                    chk($sformatf("rvalid_spurious_i%0d", i), 64'(rvalid_w[i]), 64'd0);
                end else begin
                    chk($sformatf("rvalid_ch_i%0d", i), 64'(rvalid_w[i]),
                        64'(2'b01 << sb_q[idx].ch));
                    chk($sformatf("rdata_i%0d", i), 64'(rdata_w[i]), 64'(sb_q[idx].data));
                    chk($sformatf("resp_cycle_i%0d", i), 64'(cyc), 64'(sb_q[idx].cyc));
                    sb_q.delete(idx);
                end
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic do_reset();
        track   = '0;
        ch_req  = '0;
        ch_we   = '0;
        ch_kill = '0;
        ch_addr = '0;
        ch_wdata = '0;
        ch_size = '0;
        sb_q.delete();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
    endtask

    task automatic drive(input logic ch, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] sz);
        ch_req[ch]              = req;
        ch_we[ch]               = we;
        ch_addr[ch*32 +: 32]    = addr;
        ch_wdata[ch*32 +: 32]   = wd;
        ch_size[ch*3 +: 3]      = sz;
    endtask

    task automatic push(input int inst, input int ch, input logic [31:0] d, input int c);
        exp_t e;
        e.inst = inst;
        e.ch   = ch;
        e.data = d;
        e.cyc  = c;
        sb_q.push_back(e);
    endtask

    task automatic out_zero(input int i, input string tag);
        chk({tag, "_ctl"}, 64'({gnt_w[i], rvalid_w[i], busy_w[i], en_w[i], we_w[i], msize_w[i]}),
            64'd0);
        chk({tag, "_rdata"}, 64'(rdata_w[i]), 64'd0);
        chk({tag, "_maddr"}, 64'(maddr_w[i]), 64'd0);
        chk({tag, "_mwdata"}, 64'(mwdata_w[i]), 64'd0);
    endtask

    initial begin
        // Reset state of every configuration.
        do_reset();
        @(negedge clk);
        for (int i = 0; i < NI; i++) out_zero(i, $sformatf("reset_i%0d", i));

        // Reset mid-WAIT, MEM_LAT=3 (instance 2).
        track = 4'b0100;
        goto(5);
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, SZ_W);
        @(negedge clk);
        chk("rst_wait_gnt", 64'(gnt_w[2]), 64'(2'b01));
        goto(6);
        drive(1'b0, 1'b0, 1'b0, 32'h10, 32'h0, SZ_W);
        goto(8);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_wait_busy", 64'(busy_w[2]), 64'd1);
        goto(9);
        rst = 1'b0;
        @(negedge clk);
        out_zero(2, "rst_wait_after");
        goto(10);
        drive(1'b1, 1'b1, 1'b0, 32'h44, 32'h0, SZ_W);
        push(2, 1, mem_fn(32'h44), 15);
        @(negedge clk);
        chk("rst_wait_regnt", 64'(gnt_w[2]), 64'(2'b10));
        chk("rst_wait_no_rvalid", 64'(rvalid_w[2]), 64'd0);
        goto(11);
        drive(1'b1, 1'b0, 1'b0, 32'h44, 32'h0, SZ_W);
        goto(17);
        chk("rst_wait_drain", 64'(sb_q.size()), 64'd0);

        // Single load, MEM_LAT=1, with a non-owner kill in flight.
        do_reset();
        track = 4'b0001;
        goto(5);
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, SZ_W);
        push(0, 1, 32'hDEAD_BEEF, 8);
        @(negedge clk);
        chk("load_gnt", 64'(gnt_w[0]), 64'(2'b10));
        goto(6);
        drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, SZ_W);
        ch_kill = 2'b01;
        @(negedge clk);
        chk("load_en", 64'({en_w[0], we_w[0], busy_w[0]}), 64'(3'b101));
        chk("load_addr", 64'(maddr_w[0]), 64'h40);
        chk("load_size", 64'(msize_w[0]), 64'(SZ_W));
        chk("load_gnt_issue", 64'(gnt_w[0]), 64'd0);
        goto(7);
        @(negedge clk);
        chk("load_en_wait", 64'(en_w[0]), 64'd0);
        goto(9);
        ch_kill = 2'b00;
        @(negedge clk);
        chk("load_idle", 64'(busy_w[0]), 64'd0);
        chk("load_rdata_hold", 64'(rdata_w[0]), 64'hDEAD_BEEF);
        chk("load_drain", 64'(sb_q.size()), 64'd0);

        // Conflict, fixed priority: ch0 store wins, ch1 granted in RESP.
        do_reset();
        track = 4'b0001;
        goto(5);
        drive(1'b0, 1'b1, 1'b1, 32'h100, 32'h1234_5678, SZ_W);
        drive(1'b1, 1'b1, 1'b0, 32'h8, 32'h0, SZ_W);
        push(0, 0, mem_fn(32'h100), 8);
        push(0, 1, mem_fn(32'h8), 11);
        @(negedge clk);
        chk("conf_gnt0", 64'(gnt_w[0]), 64'(2'b01));
        goto(6);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, SZ_B);
        @(negedge clk);
        chk("conf_store", 64'({en_w[0], we_w[0]}), 64'(2'b11));
        chk("conf_addr", 64'(maddr_w[0]), 64'h100);
        chk("conf_wdata", 64'(mwdata_w[0]), 64'h1234_5678);
        chk("conf_nognt_issue", 64'(gnt_w[0]), 64'd0);
        goto(7);
        @(negedge clk);
        chk("conf_nognt_wait", 64'(gnt_w[0]), 64'd0);
        goto(8);
        @(negedge clk);
        chk("conf_gnt1", 64'(gnt_w[0]), 64'(2'b10));
        goto(9);
        drive(1'b1, 1'b0, 1'b0, 32'h8, 32'h0, SZ_W);
        @(negedge clk);
        chk("conf_fetch", 64'({en_w[0], we_w[0]}), 64'(2'b10));
        chk("conf_fetch_addr", 64'(maddr_w[0]), 64'h8);
        goto(12);
        chk("conf_drain", 64'(sb_q.size()), 64'd0);

        // Continuous requests: round-robin alternates, fixed priority starves ch1.
        do_reset();
        track = 4'b0011;
        goto(5);
        drive(1'b0, 1'b1, 1'b0, 32'h200, 32'h0, SZ_W);
        drive(1'b1, 1'b1, 1'b0, 32'h300, 32'h0, SZ_BU);
        for (int n = 0; n < 6; n++) begin
            goto(5 + 3 * n);
            @(negedge clk);
            chk($sformatf("rr_gnt_%0d", n), 64'(gnt_w[1]),
                64'((n % 2 == 1) ? 2'b10 : 2'b01));
            chk($sformatf("fix_gnt_%0d", n), 64'(gnt_w[0]), 64'(2'b01));
            push(1, n % 2, mem_fn((n % 2 == 1) ? 32'h300 : 32'h200), 8 + 3 * n);
            push(0, 0, mem_fn(32'h200), 8 + 3 * n);
            goto(6 + 3 * n);
            @(negedge clk);
            chk($sformatf("rr_gap_%0d", n), 64'({gnt_w[1], gnt_w[0]}), 64'd0);
        end
        ch_req = 2'b00;
        goto(25);
        chk("rr_drain", 64'(sb_q.size()), 64'd0);

        // Kill: fetch killed in WAIT, then a store killed from ISSUE.
        do_reset();
        track = 4'b0001;
        goto(5);
        drive(1'b0, 1'b1, 1'b0, 32'h80, 32'h0, SZ_W);
        push(0, 0, mem_fn(32'h80), 8);
        @(negedge clk);
        chk("kill_pre_gnt", 64'(gnt_w[0]), 64'(2'b01));
        goto(6);
        drive(1'b0, 1'b0, 1'b0, 32'h80, 32'h0, SZ_W);
        goto(9);
        drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, SZ_W);
        @(negedge clk);
        chk("kill_fetch_gnt", 64'(gnt_w[0]), 64'(2'b10));
        goto(10);
        drive(1'b1, 1'b0, 1'b0, 32'h40, 32'h0, SZ_W);
        goto(11);
        ch_kill = 2'b10;
        @(negedge clk);
        chk("kill_rdata_wait", 64'(rdata_w[0]), 64'(mem_fn(32'h80)));
        goto(12);
        ch_kill = 2'b00;
        @(negedge clk);
        chk("kill_fetch_norv", 64'(rvalid_w[0]), 64'd0);
        chk("kill_fetch_rdata", 64'(rdata_w[0]), 64'(mem_fn(32'h80)));
        goto(13);
        drive(1'b0, 1'b1, 1'b1, 32'h104, 32'hCAFE_F00D, SZ_W);
        ch_kill = 2'b01;
        @(negedge clk);
        chk("kill_store_gnt", 64'(gnt_w[0]), 64'(2'b01));
        goto(14);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, SZ_B);
        @(negedge clk);
        chk("kill_store_en", 64'({en_w[0], we_w[0]}), 64'(2'b11));
        chk("kill_store_addr", 64'(maddr_w[0]), 64'h104);
        chk("kill_store_wdata", 64'(mwdata_w[0]), 64'hCAFE_F00D);
        goto(15);
        ch_kill = 2'b00;
        goto(16);
        @(negedge clk);
        chk("kill_store_norv", 64'(rvalid_w[0]), 64'd0);
        chk("kill_store_busy", 64'(busy_w[0]), 64'd1);
        chk("kill_store_rdata", 64'(rdata_w[0]), 64'(mem_fn(32'h80)));
        goto(17);
        @(negedge clk);
        chk("kill_store_idle", 64'(busy_w[0]), 64'd0);
        chk("kill_drain", 64'(sb_q.size()), 64'd0);

        // MEM_LAT=4 sweep (instance 3).
        do_reset();
        track = 4'b1000;
        goto(5);
        drive(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, SZ_H);
        push(3, 0, mem_fn(32'h20), 11);
        @(negedge clk);
        chk("lat4_gnt", 64'(gnt_w[3]), 64'(2'b01));
        chk("lat4_busy_t", 64'(busy_w[3]), 64'd0);
        for (int c = 6; c <= 12; c++) begin
            goto(c);
            if (c == 6) drive(1'b0, 1'b0, 1'b0, 32'h20, 32'h0, SZ_H);
            @(negedge clk);
            chk($sformatf("lat4_en_c%0d", c), 64'(en_w[3]), 64'(c == 6));
            chk($sformatf("lat4_busy_c%0d", c), 64'(busy_w[3]), 64'(c <= 11));
            chk($sformatf("lat4_gnt_c%0d", c), 64'(gnt_w[3]), 64'd0);
            if (c == 6) chk("lat4_size", 64'(msize_w[3]), 64'(SZ_H));
        end
        chk("lat4_drain", 64'(sb_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
